// File: rtl/matmul_flags_collector.sv
// Gathers per-PE overflow pulses into a sticky vector for one matmul operation,
// then writes it to the flags register and signals completion.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start_i; sticky vector holds last result
// S_RUN   | accumulating pe_ovf_i for len compute cycles
// S_WRITE | flag_we_o pulse, flag_data_o carries the final sticky vector
// S_DONE  | done_o pulse to the matmul controller
module matmul_flags_collector #(
    parameter int DATA_WIDTH = 32,
    parameter int BUS_WIDTH  = 64,
    parameter int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         start_i,
    input  logic [CNT_WIDTH-1:0]         op_len_i,
    input  logic                         clear_i,
    input  logic [MAX_DIM*MAX_DIM-1:0]   pe_ovf_i,
    output logic                         flag_we_o,
    output logic [MAX_DIM*MAX_DIM-1:0]   flag_data_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         ovf_any_o
);

    localparam int NF = MAX_DIM * MAX_DIM;
    localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   len_q, len_d;
    logic [NF-1:0]          sticky_q, sticky_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            len_q    <= '0;
            sticky_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            sticky_q <= sticky_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        sticky_d = sticky_q;

        if (clear_i) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            sticky_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_d  = S_RUN;
                        cnt_d    = '0;
                        sticky_d = '0;
                        // A zero length still runs one compute cycle
                        len_d    = (op_len_i == '0) ? ONE : op_len_i;
                    end
                end
                S_RUN: begin
                    sticky_d = sticky_q | pe_ovf_i;
                    if (cnt_q == len_q - ONE) begin
                        state_d = S_WRITE;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                S_WRITE: state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign flag_we_o   = (state_q == S_WRITE);
    assign done_o      = (state_q == S_DONE);
    assign flag_data_o = sticky_q;
    assign ovf_any_o   = |sticky_q;

endmodule

// File: tb/tb_matmul_flags_collector.sv
// Randomized and directed checks of matmul_flags_collector against a
// per-operation timeline model (expected outputs per cycle after start).
module tb_matmul_flags_collector;

    localparam int NF = 4;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            start_i;
    logic [7:0]      op_len_i;
    logic            clear_i;
    logic [NF-1:0]   pe_ovf_i;
    logic            flag_we_o;
    logic [NF-1:0]   flag_data_o;
    logic            busy_o;
    logic            done_o;
    logic            ovf_any_o;

    int checks = 0;
    int errors = 0;
    logic [NF-1:0] ovf_seq [0:300];

    matmul_flags_collector #(
        .DATA_WIDTH(32),
        .BUS_WIDTH (64),
        .CNT_WIDTH (8)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (start_i),
        .op_len_i   (op_len_i),
        .clear_i    (clear_i),
        .pe_ovf_i   (pe_ovf_i),
        .flag_we_o  (flag_we_o),
        .flag_data_o(flag_data_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .ovf_any_o  (ovf_any_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input bit busy, input bit we, input bit done,
                              input logic [NF-1:0] data);
        check_val({tag, "_busy"}, 32'(busy_o), 32'(busy));
        check_val({tag, "_we"},   32'(flag_we_o), 32'(we));
        check_val({tag, "_done"}, 32'(done_o), 32'(done));
        check_val({tag, "_data"}, 32'(flag_data_o), 32'(data));
        check_val({tag, "_any"},  32'(ovf_any_o), 32'(|data));
    endtask

    // One operation; ovf_seq[1..L] drives the RUN cycles. clr_at/bstart_at are
    // cycle numbers after the start edge (0 = none).
    task automatic run_op(input string tag, input int len_in, input int clr_at, input int bstart_at);
        int L;
        logic [NF-1:0] acc;
        bit aborted;
        L = (len_in == 0) ? 1 : len_in;
        @(negedge clk_i);
        start_i  = 1'b1;
        op_len_i = len_in[7:0];
        clear_i  = 1'b0;
        pe_ovf_i = NF'($urandom);
        @(posedge clk_i);
        acc = '0;
        for (int n = 1; n <= L + 3; n++) begin
            @(negedge clk_i);
            aborted = (clr_at != 0) && (n > clr_at);
            if (aborted)
                check_outs(tag, 1'b0, 1'b0, 1'b0, '0);
            else
                check_outs(tag, n <= L + 2, n == L + 1, n == L + 2, acc);
            start_i  = (n == bstart_at);
            op_len_i = 8'($urandom);
            pe_ovf_i = (n <= L) ? ovf_seq[n] : NF'($urandom);
            clear_i  = (n == clr_at);
            if (n <= L) acc |= ovf_seq[n];
            @(posedge clk_i);
        end
        @(negedge clk_i);
        start_i = 1'b0;
        clear_i = 1'b0;
    endtask

    initial begin
        int len, clr, bst, L;
        rst_ni   = 1'b0;
        start_i  = 1'b0;
        clear_i  = 1'b0;
        op_len_i = '0;
        pe_ovf_i = '0;

        // Reset then idle with overflow pulses that must be ignored
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_outs("rst", 1'b0, 1'b0, 1'b0, '0);
        rst_ni   = 1'b1;
        pe_ovf_i = 4'hF;
        repeat (3) @(negedge clk_i);
        check_outs("idle_ovf", 1'b0, 1'b0, 1'b0, '0);
        pe_ovf_i = '0;

        // Basic op
        for (int i = 0; i <= 300; i++) ovf_seq[i] = '0;
        ovf_seq[2] = 4'b0001;
        ovf_seq[5] = 4'b1000;
        run_op("basic", 5, 0, 0);

        // Zero and one length, no overflow
        for (int i = 0; i <= 300; i++) ovf_seq[i] = '0;
        run_op("len0", 0, 0, 0);
        run_op("len1", 1, 0, 0);

        // Start while busy is ignored
        ovf_seq[3] = 4'b0100;
        run_op("busy_start", 3, 0, 2);
        ovf_seq[3] = '0;

        // Abort during RUN cycle 2 with sticky = 0110
        ovf_seq[1] = 4'b0110;
        run_op("abort", 5, 2, 0);
        ovf_seq[1] = '0;

        // clear and start together in IDLE
        @(negedge clk_i);
        start_i  = 1'b1;
        clear_i  = 1'b1;
        op_len_i = 8'd4;
        @(negedge clk_i);
        start_i = 1'b0;
        clear_i = 1'b0;
        check_outs("clr_start", 1'b0, 1'b0, 1'b0, '0);
        @(negedge clk_i);
        check_outs("clr_start2", 1'b0, 1'b0, 1'b0, '0);

        // Reset during WRITE
        pe_ovf_i = 4'b0010;
        start_i  = 1'b1;
        op_len_i = 8'd3;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check_outs("pre_rst_write", 1'b1, 1'b1, 1'b0, 4'b0010);
        #1 rst_ni = 1'b0;
        #1 check_outs("async_rst", 1'b0, 1'b0, 1'b0, '0);
        repeat (2) begin
            @(negedge clk_i);
            check_outs("in_rst", 1'b0, 1'b0, 1'b0, '0);
        end
        rst_ni   = 1'b1;
        pe_ovf_i = '0;
        repeat (2) @(negedge clk_i);
        check_outs("post_rst", 1'b0, 1'b0, 1'b0, '0);

        // Randomized operations
        for (int t = 0; t < 40; t++) begin
            len = $urandom_range(0, 12);
            L   = (len == 0) ? 1 : len;
            for (int i = 1; i <= L; i++)
                ovf_seq[i] = ($urandom_range(0, 3) == 0) ? NF'($urandom) : '0;
            clr = ($urandom_range(0, 9) < 3) ? $urandom_range(1, L + 2) : 0;
            bst = 0;
            if ($urandom_range(0, 9) < 3)
                bst = $urandom_range(1, (clr != 0) ? clr : L + 2);
            run_op("rand", len, clr, bst);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matmul_flags_collector.md
Name: matmul_flags_collector

Overview:
- Sits directly upstream of the matmul flags register and drives its write-enable and data inputs.
- During one matmul operation it gathers per-PE overflow/underflow pulses from the systolic array into a sticky MAX_DIM^2-bit vector.
- When the operation ends it issues a single-cycle write of that vector to the flags register, then a done pulse to the matmul controller.

Parameters:
- DATA_WIDTH, 32, operand data width in bits.
- BUS_WIDTH, 64, bus width in bits.
- MAX_DIM, BUS_WIDTH/DATA_WIDTH, matrix dimension. The flag vector is MAX_DIM*MAX_DIM bits, and bit r*MAX_DIM+c is PE (r,c).
- CNT_WIDTH, 8, width of the operation-length counter.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- start_i  input  1  begins an operation when sampled high in IDLE.
- op_len_i  input  CNT_WIDTH  number of compute cycles in the operation; latched on an accepted start.
- clear_i  input  1  synchronous abort/clear.
- pe_ovf_i  input  MAX_DIM*MAX_DIM  per-PE overflow/underflow pulses; bit i set = PE i overflowed this cycle.
- flag_we_o  output  1  write enable to the flags register; single-cycle pulse.
- flag_data_o  output  MAX_DIM*MAX_DIM  sticky flag vector, driven directly from the sticky register.
- busy_o  output  1  high while an operation is in progress.
- done_o  output  1  single-cycle completion pulse.
- ovf_any_o  output  1  OR-reduction of the sticky vector.

Behaviour:
- Reset, asynchronous and active-low:
  - state=IDLE, cnt=0, len=0, sticky=0.
  - Outputs: flag_we_o=0, done_o=0, busy_o=0, flag_data_o=0, ovf_any_o=0.
  - Reset asserted mid-operation aborts immediately. No flag write occurs.
- States: IDLE, RUN, WRITE, DONE. busy_o=1 in RUN, WRITE and DONE; flag_we_o=1 only in WRITE; done_o=1 only in DONE. All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- IDLE:
  - start_i=1 → RUN; sticky<=0, cnt<=0, len<=max(op_len_i,1). op_len_i=0 is treated as 1.
  - pe_ovf_i is ignored in IDLE.
- RUN:
  - Each cycle: sticky <= sticky | pe_ovf_i, cnt <= cnt+1.
  - When cnt==len-1 → WRITE. The last RUN cycle's pe_ovf_i is included in the sticky vector.
- WRITE: lasts exactly 1 cycle and presents flag_we_o=1 with flag_data_o=final sticky. Then → DONE.
- DONE: lasts 1 cycle with done_o=1, then → IDLE. sticky holds its value in IDLE until the next accepted start or a clear.
- Latency: start sampled at edge k gives flag_we_o high in cycle k+L+1 and done_o high in cycle k+L+2, where L=len.
- start_i while busy_o=1 is ignored. It is not queued.
- clear_i=1 in any state → IDLE, sticky<=0, cnt<=0, and no write or done pulse. clear_i has priority over start_i in the same cycle.
- The counter never wraps: len ≤ 2^CNT_WIDTH−1, and cnt stops at len-1.
- A flag bit, once set, stays set until the next start, clear_i or reset.

Test Plan (MAX_DIM=2, 4 flag bits):
- Reset then idle: hold rst_ni=0 for 3 cycles, then release with no start → all outputs 0; pe_ovf_i=4'hF in IDLE leaves flag_data_o=0.
- Basic op: start_i at edge k, op_len_i=5, pe_ovf_i=4'b0001 in RUN cycle 2 and 4'b1000 in the last RUN cycle → flag_we_o high only in cycle k+6 with flag_data_o=4'b1001, done_o high only in cycle k+7, ovf_any_o=1.
- Zero/one length: op_len_i=0 and separately op_len_i=1 → both give exactly 1 RUN cycle, flag_we_o at k+2 and done_o at k+3; no overflow gives flag_data_o=4'b0000.
- Start while busy: second start_i pulse during RUN with op_len_i=3 → ignored; exactly one flag_we_o pulse; timing follows the first op_len_i.
- Abort: clear_i in RUN cycle 2 with sticky=4'b0110 → next cycle state IDLE, flag_data_o=0, no flag_we_o and no done_o. clear_i and start_i together in IDLE → stays IDLE.
- Reset mid-op: rst_ni low during WRITE → flag_we_o drops asynchronously, no done_o, and after release the block is in IDLE with sticky=0.
